sky130_sram_1rw1r_param: RTL and testbench
==========================================

Name: sky130_sram_1rw1r_param

Overview:
Parametrised single-clock 1RW+1R SRAM behavioural model; the next-generation replacement for the fixed 32x512 OpenRAM macro models. It adds configurable width, depth and byte-write granularity, a selectable read latency, defined read/write collision handling, read-valid strobes and collision status. Both ports run on one clock, and all state is posedge-sampled. Used in SoC simulation wherever an OpenRAM 1rw1r macro is instantiated.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of WRITE_SIZE.
WRITE_SIZE, 8, bits per write-mask lane; NUM_WMASKS = DATA_WIDTH/WRITE_SIZE (derived localparam).
ADDR_WIDTH, 9, address bits.
RAM_DEPTH, 1<<ADDR_WIDTH, number of implemented words; must be <= 2^ADDR_WIDTH.
READ_LATENCY, 1, allowed values 1 or 2; counted in edges from the sampling edge to the dout/rvalid update.
COLLISION_MODE, 1, 0 = READ_OLD, 1 = WRITE_THROUGH, 2 = READ_X.

Ports:
clk0  input  1  single clock for both ports
rstb0  input  1  asynchronous active-low reset
csb0  input  1  port0 active-low chip select
web0  input  1  port0 active-low write enable
wmask0  input  NUM_WMASKS  port0 lane write mask
addr0  input  ADDR_WIDTH  port0 address
din0  input  DATA_WIDTH  port0 write data
dout0  output  DATA_WIDTH  port0 read data
rvalid0  output  1  port0 read data valid strobe
csb1  input  1  port1 active-low chip select
addr1  input  ADDR_WIDTH  port1 address
dout1  output  DATA_WIDTH  port1 read data
rvalid1  output  1  port1 read data valid strobe
coll_pulse  output  1  collision detected, aligned with the rvalid1 of the colliding read
coll_sticky  output  1  sticky collision flag
coll_clr  input  1  synchronous clear of coll_sticky

Behaviour:
- Reset (rstb0 low, asynchronous): dout0, dout1 = 0; rvalid0, rvalid1, coll_pulse, coll_sticky = 0; pipeline stage registers cleared.
- Memory contents are not reset. While rstb0 is low, writes and reads are inhibited.
- Reads in flight when reset asserts are discarded. No rvalid pulse follows reset release for them.
- Sampling: all inputs are sampled at posedge clk0.
- Port0 access: csb0=0. web0=0 is a write; web0=1 is a read.
- Port1 access: csb1=0 is a read.
- Write at edge N: lane i of mem[addr0] <= din0 lane i when wmask0[i]=1. Lanes with a zero mask bit are unchanged. wmask0=0 is a no-op.
- Read at edge N with READ_LATENCY=1: dout and rvalid update at edge N. Data is usable at edge N+1.
- Read at edge N with READ_LATENCY=2: one extra register stage; dout and rvalid update at edge N+1.
- rvalid0/rvalid1 are one-cycle pulses per read; back-to-back reads give continuous high.
- dout0/dout1 hold their last value when no read completes.
- A port0 write never changes dout0 and never raises rvalid0.
- Out-of-range address (addr >= RAM_DEPTH): write ignored; read returns all zeros with rvalid still asserted.
- Collision: port0 write with nonzero wmask0 and a port1 read to the same in-range address at the same edge. Port1 data depends on COLLISION_MODE:
  - READ_OLD: pre-write word.
  - WRITE_THROUGH: merged word (masked lanes new, others old).
  - READ_X: masked lanes X, others old.
- On collision: coll_pulse is high with that read's rvalid1, and coll_sticky is set.
- coll_clr clears coll_sticky. If coll_clr and a new collision pulse coincide, set wins.
- Port0 read and port1 read to the same address: no collision; both return the current word.
- Stalls: none. Each port accepts one access per cycle, every cycle.
- Elaboration: an illegal parameter (READ_LATENCY not 1 or 2, DATA_WIDTH % WRITE_SIZE != 0, RAM_DEPTH > 2^ADDR_WIDTH) is an elaboration-time error.

Decomposition:
- Shared package sky130_sram_pkg holds:
  - COLLISION_MODE encodings (COLL_READ_OLD=0, COLL_WRITE_THROUGH=1, COLL_READ_X=2)
  - a lane-merge function (old, new, mask)
  - the parameter legality checks
- One sub-module, sky130_sram_rd_pipe: per-port output stage carrying data, valid and collision flag. It is 1 or 2 stages deep and has async reset. It is instantiated once per port (collision input tied 0 on port0).

Test Plan:
- Masked write then read: write addr0=0x010 din0=0xAABBCCDD wmask0=0xF, then write 0x11223344 wmask0=0x5, then port1 read 0x010 -> dout1=0xAA22CC44 with a 1-cycle rvalid1 at latency 1.
- Latency: READ_LATENCY=2, back-to-back port0 reads of addr 1 and addr 2 holding 0x1 and 0x2 -> rvalid0 high for 2 consecutive cycles, starting one edge later than in the latency-1 build, data 0x1 then 0x2.
- Collision, per mode: mem[5]=0x00000000, same-edge port0 write 0xFFFFFFFF wmask0=0x3 and port1 read 5 -> mode0 dout1=0x00000000; mode1 0x0000FFFF; mode2 0x0000XXXX. coll_pulse=1 with rvalid1 and coll_sticky=1; then coll_clr -> coll_sticky=0.
- Out-of-range: RAM_DEPTH=384, write addr 400 then read addr 400 -> dout=0, rvalid=1; mem[400 mod 384] unchanged.
- Reset mid-read: issue a port1 read, assert rstb0 before the result edge -> dout1=0, rvalid1=0, no later rvalid1. A write before reset persists and reads back after rstb0 release.
- Idle hold: port0 read of 0xDEADBEEF, then csb0=1 for 10 cycles -> dout0 stays 0xDEADBEEF, rvalid0=0.

Source files
------------

// File: rtl/sky130_sram_pkg.sv
// rtl/sky130_sram_pkg.sv - shared encodings, lane merge and parameter legality for the 1rw1r SRAM model
package sky130_sram_pkg;

  localparam int COLL_READ_OLD      = 0;
  localparam int COLL_WRITE_THROUGH = 1;
  localparam int COLL_READ_X        = 2;

  // Widest word the lane-merge helper handles; callers size-cast in and out.
  localparam int MAX_WIDTH = 256;
  localparam int MAX_LANES = 256;

  function automatic logic [MAX_WIDTH-1:0] lane_merge(
    input logic [MAX_WIDTH-1:0] old_word,
    input logic [MAX_WIDTH-1:0] new_word,
    input logic [MAX_LANES-1:0] mask,
    input int                   lane_bits
  );
    logic [MAX_WIDTH-1:0] merged;
    logic [7:0]           lane;
    for (int b = 0; b < MAX_WIDTH; b++) begin
      lane      = 8'(b / lane_bits);
      merged[b] = mask[lane] ? new_word[b] : old_word[b];
    end
    return merged;
  endfunction

  function automatic bit params_ok(
    input int data_width,
    input int write_size,
    input int addr_width,
    input int ram_depth,
    input int read_latency,
    input int collision_mode
  );
    return (read_latency == 1 || read_latency == 2) &&
           write_size > 0 && data_width > 0 &&
           (data_width % write_size) == 0 && data_width <= MAX_WIDTH &&
           addr_width > 0 && addr_width < 31 &&
           ram_depth > 0 && ram_depth <= (1 << addr_width) &&
           collision_mode >= COLL_READ_OLD && collision_mode <= COLL_READ_X;
  endfunction

endpackage

// File: rtl/sky130_sram_rd_pipe.sv
// rtl/sky130_sram_rd_pipe.sv - per-port read output stage (1 or 2 deep) carrying data, valid and collision flag
module sky130_sram_rd_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_in,
  input  logic                  coll_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  coll_out,
  output logic                  coll_set
);

  logic [DATA_WIDTH-1:0] fin_data;
  logic                  fin_valid;
  logic                  fin_coll;

  if (LATENCY == 2) begin : g_two
    logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;
    logic                  s1_valid_q, s1_valid_d;
    logic                  s1_coll_q, s1_coll_d;

    always_comb begin
      s1_valid_d = valid_in;
      s1_coll_d  = valid_in & coll_in;
      s1_data_d  = valid_in ? data_in : s1_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_data_q  <= '0;
        s1_valid_q <= 1'b0;
        s1_coll_q  <= 1'b0;
      end else begin
        s1_data_q  <= s1_data_d;
        s1_valid_q <= s1_valid_d;
        s1_coll_q  <= s1_coll_d;
      end
    end

    assign fin_data  = s1_data_q;
    assign fin_valid = s1_valid_q;
    assign fin_coll  = s1_coll_q;
  end else begin : g_one
    assign fin_data  = data_in;
    assign fin_valid = valid_in;
    assign fin_coll  = valid_in & coll_in;
  end

  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  coll_q, coll_d;

  // Output data only moves when a read completes; otherwise it holds.
  always_comb begin
    valid_d = fin_valid;
    coll_d  = fin_coll;
    data_d  = fin_valid ? fin_data : data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      coll_q  <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      coll_q  <= coll_d;
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign coll_out  = coll_q;
  assign coll_set  = fin_coll;

endmodule

// File: rtl/sky130_sram_1rw1r_param.sv
// rtl/sky130_sram_1rw1r_param.sv - parametrised single-clock 1RW+1R SRAM model with collision handling
module sky130_sram_1rw1r_param
  import sky130_sram_pkg::*;
#(
  parameter  int DATA_WIDTH     = 32,
  parameter  int WRITE_SIZE     = 8,
  parameter  int ADDR_WIDTH     = 9,
  parameter  int RAM_DEPTH      = 1 << ADDR_WIDTH,
  parameter  int READ_LATENCY   = 1,
  parameter  int COLLISION_MODE = 1,
  localparam int NUM_WMASKS     = DATA_WIDTH / WRITE_SIZE
) (
  input  logic                  clk0,
  input  logic                  rstb0,
  input  logic                  csb0,
  input  logic                  web0,
  input  logic [NUM_WMASKS-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  output logic [DATA_WIDTH-1:0] dout0,
  output logic                  rvalid0,
  input  logic                  csb1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic [DATA_WIDTH-1:0] dout1,
  output logic                  rvalid1,
  output logic                  coll_pulse,
  output logic                  coll_sticky,
  input  logic                  coll_clr
);

  if (!params_ok(DATA_WIDTH, WRITE_SIZE, ADDR_WIDTH, RAM_DEPTH, READ_LATENCY, COLLISION_MODE)) begin : g_bad_params
    $error("sky130_sram_1rw1r_param: illegal parameter combination");
  end

  logic [DATA_WIDTH-1:0] mem_q [RAM_DEPTH];

  logic                  in_range0, in_range1;
  logic                  wr_en, rd0_en, rd1_en, coll;
  logic [DATA_WIDTH-1:0] rd0_word, rd1_old, rd1_word, wr_word_d;

  always_comb begin
    in_range0 = int'(addr0) < RAM_DEPTH;
    in_range1 = int'(addr1) < RAM_DEPTH;
    rd0_word  = in_range0 ? mem_q[addr0] : '0;
    rd1_old   = in_range1 ? mem_q[addr1] : '0;
    wr_en     = !csb0 && !web0 && in_range0 && (|wmask0);
    rd0_en    = !csb0 && web0;
    rd1_en    = !csb1;
    coll      = wr_en && rd1_en && in_range1 && (addr0 == addr1);
    wr_word_d = DATA_WIDTH'(lane_merge(MAX_WIDTH'(rd0_word), MAX_WIDTH'(din0),
                                       MAX_LANES'(wmask0), WRITE_SIZE));
    // rd1_old is the pre-write word; the mode picks what a colliding read sees.
    rd1_word  = rd1_old;
    if (coll && COLLISION_MODE == COLL_WRITE_THROUGH) begin
      rd1_word = wr_word_d;
    end else if (coll && COLLISION_MODE == COLL_READ_X) begin
      rd1_word = DATA_WIDTH'(lane_merge(MAX_WIDTH'(rd1_old), {MAX_WIDTH{1'bx}},
                                        MAX_LANES'(wmask0), WRITE_SIZE));
    end
  end

  // Contents survive reset; only the access itself is gated by rstb0.
  always_ff @(posedge clk0) begin
    if (rstb0 && wr_en) begin
      mem_q[addr0] <= wr_word_d;
    end
  end

  logic p0_coll, p0_coll_set, p1_coll_set;
  logic p0_unused;
  assign p0_unused = p0_coll ^ p0_coll_set;

  sky130_sram_rd_pipe #(.DATA_WIDTH(DATA_WIDTH), .LATENCY(READ_LATENCY)) u_pipe0 (
    .clk       (clk0),
    .rst_n     (rstb0),
    .valid_in  (rd0_en),
    .coll_in   (1'b0),
    .data_in   (rd0_word),
    .data_out  (dout0),
    .valid_out (rvalid0),
    .coll_out  (p0_coll),
    .coll_set  (p0_coll_set)
  );

  sky130_sram_rd_pipe #(.DATA_WIDTH(DATA_WIDTH), .LATENCY(READ_LATENCY)) u_pipe1 (
    .clk       (clk0),
    .rst_n     (rstb0),
    .valid_in  (rd1_en),
    .coll_in   (coll),
    .data_in   (rd1_word),
    .data_out  (dout1),
    .valid_out (rvalid1),
    .coll_out  (coll_pulse),
    .coll_set  (p1_coll_set)
  );

  logic coll_sticky_q, coll_sticky_d;

  always_comb begin
    coll_sticky_d = coll_sticky_q;
    if (p1_coll_set) begin
      coll_sticky_d = 1'b1;
    end else if (coll_clr) begin
      coll_sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk0 or negedge rstb0) begin
    if (!rstb0) begin
      coll_sticky_q <= 1'b0;
    end else begin
      coll_sticky_q <= coll_sticky_d;
    end
  end

  assign coll_sticky = coll_sticky_q;

endmodule

// File: tb/tb_sky130_sram_1rw1r_param.sv
// tb/tb_sky130_sram_1rw1r_param.sv - scoreboard bench over three builds (lat1/READ_OLD, lat2/WRITE_THROUGH, lat1/READ_X)
module tb_sky130_sram_1rw1r_param;

  localparam int NI    = 3;
  localparam int DEPTH = 384;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstb0, csb0, web0, csb1, coll_clr;
  logic [3:0]  wmask0;
  logic [8:0]  addr0, addr1;
  logic [31:0] din0;
  logic [31:0] dout0_a [NI];
  logic [31:0] dout1_a [NI];
  logic        rvalid0_a [NI];
  logic        rvalid1_a [NI];
  logic        coll_pulse_a [NI];
  logic        coll_sticky_a [NI];

  for (genvar k = 0; k < NI; k++) begin : g_dut
    sky130_sram_1rw1r_param #(
      .DATA_WIDTH(32), .WRITE_SIZE(8), .ADDR_WIDTH(9), .RAM_DEPTH(DEPTH),
      .READ_LATENCY((k == 1) ? 2 : 1), .COLLISION_MODE(k)
    ) u_dut (
      .clk0(clk), .rstb0(rstb0), .csb0(csb0), .web0(web0), .wmask0(wmask0),
      .addr0(addr0), .din0(din0), .dout0(dout0_a[k]), .rvalid0(rvalid0_a[k]),
      .csb1(csb1), .addr1(addr1), .dout1(dout1_a[k]), .rvalid1(rvalid1_a[k]),
      .coll_pulse(coll_pulse_a[k]), .coll_sticky(coll_sticky_a[k]), .coll_clr(coll_clr)
    );
  end

  typedef struct {
    int          inst;
    int          port;
    int          due;
    logic [31:0] data;
    logic [31:0] care;
    bit          coll;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] mem_m [DEPTH];
  logic [31:0] last_d [NI][2];
  logic [31:0] last_c [NI][2];
  bit          sticky_m [NI];
  int          cyc, tests, fails;

  function automatic int lat(input int k);
    return (k == 1) ? 2 : 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < NI; k++) begin
      bit pulse = 0;
      for (int p = 0; p < 2; p++) begin
        int          idx = -1;
        logic        ov;
        logic [31:0] od;
        string       tg;
        exp_t        e;
        foreach (sb[i]) if (sb[i].inst == k && sb[i].port == p && sb[i].due == cyc) idx = i;
        ov = (p == 1) ? rvalid1_a[k] : rvalid0_a[k];
        od = (p == 1) ? dout1_a[k] : dout0_a[k];
        tg = $sformatf("u%0d p%0d cyc%0d", k, p, cyc);
        if (idx >= 0) begin
          e = sb[idx];
          sb.delete(idx);
          chk({tg, " rvalid"}, 32'(ov), 32'd1);
          chk({tg, " dout"}, od & e.care, e.data & e.care);
          if (p == 1) chk({tg, " coll_pulse"}, 32'(coll_pulse_a[k]), 32'(e.coll));
          if (p == 1) pulse = e.coll;
          last_d[k][p] = e.data;
          last_c[k][p] = e.care;
        end else begin
          chk({tg, " rvalid_idle"}, 32'(ov), 32'd0);
          chk({tg, " dout_hold"}, od & last_c[k][p], last_d[k][p] & last_c[k][p]);
          if (p == 1) chk({tg, " coll_pulse_idle"}, 32'(coll_pulse_a[k]), 32'd0);
        end
      end
      if (!rstb0) sticky_m[k] = 0;
      else if (pulse) sticky_m[k] = 1;
      else if (coll_clr) sticky_m[k] = 0;
      chk($sformatf("u%0d cyc%0d coll_sticky", k, cyc), 32'(coll_sticky_a[k]), 32'(sticky_m[k]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check_all();
  endtask

  task automatic drive(input logic c0, input logic w0, input logic [3:0] m0, input logic [8:0] a0,
                       input logic [31:0] d0, input logic c1, input logic [8:0] a1);
    logic [31:0] lm, old1, mrg;
    bit          coll;
    csb0 = c0; web0 = w0; wmask0 = m0; addr0 = a0; din0 = d0; csb1 = c1; addr1 = a1;
    if (!rstb0) return;
    for (int i = 0; i < 4; i++) lm[8*i +: 8] = {8{m0[i]}};
    if (!c0 && w0) begin
      for (int k = 0; k < NI; k++)
        sb.push_back('{k, 0, cyc + lat(k), (a0 < DEPTH) ? mem_m[a0] : 32'h0, 32'hFFFF_FFFF, 1'b0});
    end
    if (!c1) begin
      old1 = (a1 < DEPTH) ? mem_m[a1] : 32'h0;
      coll = !c0 && !w0 && (m0 != 0) && (a0 == a1) && (a1 < DEPTH);
      mrg  = (old1 & ~lm) | (d0 & lm);
      for (int k = 0; k < NI; k++)
        sb.push_back('{k, 1, cyc + lat(k), (coll && k == 1) ? mrg : old1,
                       (coll && k == 2) ? ~lm : 32'hFFFF_FFFF, coll});
    end
    if (!c0 && !w0 && a0 < DEPTH) mem_m[a0] = (mem_m[a0] & ~lm) | (d0 & lm);
  endtask

  task automatic idle(input int n);
    drive(1, 1, 4'h0, 9'd0, 32'h0, 1, 9'd0);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic assert_reset();
    rstb0 = 1'b0;
    drive(1, 1, 4'h0, 9'd0, 32'h0, 1, 9'd0);
    #1;
    sb.delete();
    for (int k = 0; k < NI; k++) begin
      last_d[k][0] = 32'h0; last_d[k][1] = 32'h0;
      last_c[k][0] = 32'hFFFF_FFFF; last_c[k][1] = 32'hFFFF_FFFF;
    end
    check_all();
  endtask

  initial begin
    tests = 0; fails = 0; cyc = 0;
    rstb0 = 1'b1; coll_clr = 1'b0;
    csb0 = 1; web0 = 1; wmask0 = 0; addr0 = 0; din0 = 0; csb1 = 1; addr1 = 0;
    for (int k = 0; k < NI; k++) sticky_m[k] = 0;
    #2;
    assert_reset();
    idle(3);
    rstb0 = 1'b1;

    for (int i = 0; i < 16; i++) begin
      drive(0, 0, 4'hF, 9'(i), 32'h1000_0000 + 32'(i) * 32'h0101_0101, 1, 9'd0);
      tick();
    end

    drive(0, 0, 4'hF, 9'h010, 32'hAABB_CCDD, 1, 9'd0); tick();
    drive(0, 0, 4'h5, 9'h010, 32'h1122_3344, 1, 9'd0); tick();
    drive(1, 1, 4'h0, 9'd0, 32'h0, 0, 9'h010); tick();
    chk("tp_masked_write", dout1_a[0], 32'hAA22_CC44);
    idle(2);

    drive(0, 0, 4'hF, 9'd1, 32'h1, 1, 9'd0); tick();
    drive(0, 0, 4'hF, 9'd2, 32'h2, 1, 9'd0); tick();
    drive(0, 1, 4'h0, 9'd1, 32'h0, 1, 9'd0); tick();
    drive(0, 1, 4'h0, 9'd2, 32'h0, 1, 9'd0); tick();
    idle(3);

    drive(0, 0, 4'hF, 9'd5, 32'h0, 1, 9'd0); tick();
    drive(0, 0, 4'h3, 9'd5, 32'hFFFF_FFFF, 0, 9'd5); tick();
    drive(1, 1, 4'h0, 9'd0, 32'h0, 0, 9'd5); tick();
    idle(2);
    coll_clr = 1'b1;
    drive(0, 0, 4'h1, 9'd5, 32'h0000_00AB, 0, 9'd5); tick();
    idle(1);
    coll_clr = 1'b0;
    idle(2);
    coll_clr = 1'b1;
    idle(1);
    coll_clr = 1'b0;
    idle(2);

    drive(0, 0, 4'hF, 9'd400, 32'h1234_5678, 0, 9'd400); tick();
    drive(0, 1, 4'h0, 9'd400, 32'h0, 0, 9'd400); tick();
    drive(0, 1, 4'h0, 9'h010, 32'h0, 0, 9'h010); tick();
    idle(2);

    drive(0, 0, 4'hF, 9'd7, 32'hDEAD_BEEF, 1, 9'd0); tick();
    drive(0, 1, 4'h0, 9'd7, 32'h0, 1, 9'd0); tick();
    idle(10);
    chk("tp_idle_hold", dout0_a[0], 32'hDEAD_BEEF);

    drive(0, 1, 4'h0, 9'd7, 32'h0, 0, 9'd7); tick();
    drive(0, 0, 4'h0, 9'd7, 32'h5555_5555, 0, 9'd7); tick();
    idle(2);

    drive(1, 1, 4'h0, 9'd0, 32'h0, 0, 9'd7); tick();
    assert_reset();
    idle(3);
    rstb0 = 1'b1;
    idle(4);
    drive(0, 1, 4'h0, 9'd7, 32'h0, 0, 9'd7); tick();
    idle(2);

    for (int n = 0; n < 80; n++) begin
      coll_clr = ($urandom_range(0, 7) == 0);
      drive(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            ($urandom_range(0, 9) == 0) ? 9'd390 : 9'($urandom_range(0, 15)), $urandom,
            1'($urandom_range(0, 3) == 0), 9'($urandom_range(0, 15)));
      tick();
    end
    coll_clr = 1'b0;
    idle(3);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
